// File: rtl/mult_serial_ctrl.sv
// Bit-serial shift-add multiplier: loads A then B MSB-first, multiplies, streams the 2N-bit product out MSB-first.
// Define MULT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module mult_serial_ctrl #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           in,
    output logic           out,
    output logic           out_valid,
    output logic           done,
    output logic           busy,
    output logic [2*N-1:0] product,
    output logic [2:0]     dbg_state
);
    localparam int CW = $clog2(2*N) + 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD_A    = 3'd1,
        LOAD_B    = 3'd2,
        MULT      = 3'd3,
        SHIFT_OUT = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t         state;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] acc;
    logic [2*N-1:0] sreg;
    logic [CW-1:0]  cnt;

    logic [2*N-1:0] a_ext;
    logic [2*N-1:0] addend;
    logic [2*N-1:0] acc_next;
    logic           last_step;

    assign dbg_state = state;

    // b is shifted right during MULT so b[0] is always the multiplier bit of the current step.
    always_comb begin
`ifdef MULT_SIGNED_EN
        a_ext = {{N{a[N-1]}}, a};
`else
        a_ext = {{N{1'b0}}, a};
`endif
        addend    = a_ext << cnt;
        last_step = (cnt == CW'(N-1));
        acc_next  = acc;
        if (b[0]) begin
`ifdef MULT_SIGNED_EN
            if (last_step) acc_next = acc - addend;
            else           acc_next = acc + addend;
`else
            acc_next = acc + addend;
`endif
        end
    end

    // out_valid qualifies out for each product bit; there is no backpressure on the output stream.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            a         <= '0;
            b         <= '0;
            acc       <= '0;
            sreg      <= '0;
            cnt       <= '0;
            product   <= '0;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= LOAD_A;
                        a     <= '0;
                        b     <= '0;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                LOAD_A: begin
                    a <= {a[N-2:0], in};
                    if (last_step) begin
                        state <= LOAD_B;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                LOAD_B: begin
                    b <= {b[N-2:0], in};
                    if (last_step) begin
                        state <= MULT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                MULT: begin
                    acc <= acc_next;
                    b   <= b >> 1;
                    if (last_step) begin
                        product   <= acc_next;
                        sreg      <= {acc_next[2*N-2:0], 1'b0};
                        out       <= acc_next[2*N-1];
                        out_valid <= 1'b1;
                        state     <= SHIFT_OUT;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SHIFT_OUT: begin
                    if (cnt == CW'(2*N-1)) begin
                        out       <= 1'b0;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                        cnt       <= '0;
                    end else begin
                        out  <= sreg[2*N-1];
                        sreg <= sreg << 1;
                        cnt  <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out       <= 1'b0;
                    out_valid <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mult_serial_ctrl.sv
// Directed bench for mult_serial_ctrl (N=4): driver pushes expected products and start edges, a monitor checks the serial stream.
module tb_mult_serial_ctrl;
    localparam int N = 4;
    localparam int W = 2*N;
`ifdef MULT_SIGNED_EN
    localparam bit SGN = 1'b1;
`else
    localparam bit SGN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         ser_in = 1'b0;
    logic         out;
    logic         out_valid;
    logic         done;
    logic         busy;
    logic [W-1:0] product;
    logic [2:0]   dbg_state;

    logic [W-1:0] exp_q[$];
    int           st_q[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           n_ops = 0;
    int           n_done = 0;

    mult_serial_ctrl #(.N(N)) dut (
        .clk(clk), .reset(reset), .start(start), .in(ser_in),
        .out(out), .out_valid(out_valid), .done(done), .busy(busy),
        .product(product), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pick(input logic [W-1:0] u, input logic [W-1:0] s);
        return SGN ? s : u;
    endfunction

    // Called with the DUT idle; returns at #1 after the DONE->IDLE edge.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic [W-1:0] exp,
                         input bit hold, input bit pulse);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        st_q.push_back(cyc);
        exp_q.push_back(exp);
        n_ops++;
        start = hold;
        for (int i = N-1; i >= 0; i--) begin
            ser_in = a[i];
            @(posedge clk); #1;
        end
        for (int i = N-1; i >= 0; i--) begin
            ser_in = b[i];
            if (pulse && i == 1) start = 1'b1;
            @(posedge clk); #1;
            start = hold;
        end
        ser_in = 1'b0;
        for (int j = 0; j < 3*N+1; j++) begin
            if (pulse && j == N+2) start = 1'b1;
            @(posedge clk); #1;
            start = hold;
        end
    endtask

    task automatic reset_mid_mult();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2*N; i++) begin
            ser_in = 1'b1;
            @(posedge clk); #1;
        end
        ser_in = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out", out, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_product", product, 0);
        chk("rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("no_resume_busy", busy, 0);
            chk("no_resume_state", dbg_state, 0);
        end
    endtask

    // Monitor: assembles the serial product and checks it, its latency and the parallel product on done.
    logic [W-1:0] rx;
    int           rx_cnt = 0;
    logic         done_d = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            rx_cnt = 0;
        end else begin
            if (out_valid) begin
                if (rx_cnt == 0) begin
                    if (st_q.size() == 0) chk("valid_unexpected", 1, 0);
                    else chk("first_bit_latency", cyc, st_q[0] + 3*N);
                end
                rx = {rx[W-2:0], out};
                rx_cnt++;
            end else begin
                chk("out_idle_zero", out, 0);
            end
            if (done) begin
                n_done++;
                chk("done_width", done_d, 0);
                chk("out_bits", rx_cnt, W);
                if (exp_q.size() == 0 || st_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    chk("done_latency", cyc, st_q[0] + 5*N);
                    chk("serial_product", rx, exp_q[0]);
                    chk("par_product", product, exp_q[0]);
                    void'(exp_q.pop_front());
                    void'(st_q.pop_front());
                end
                rx_cnt = 0;
            end
        end
        done_d = done;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        #12;
        chk("reset_out", out, 0);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_product", product, 0);
        chk("reset_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        do_op(4'b1011, 4'b0011, pick(8'h21, 8'hF1), 1'b0, 1'b0);
        do_op(4'b1111, 4'b1111, pick(8'hE1, 8'h01), 1'b0, 1'b0);
        do_op(4'b0000, 4'b1010, pick(8'h00, 8'h00), 1'b0, 1'b0);
        do_op(4'b1000, 4'b1000, pick(8'h40, 8'h40), 1'b0, 1'b0);
        do_op(4'b1111, 4'b0111, pick(8'h69, 8'hF9), 1'b0, 1'b0);
        do_op(4'b1011, 4'b0011, pick(8'h21, 8'hF1), 1'b0, 1'b1);
        reset_mid_mult();
        do_op(4'b0011, 4'b0010, pick(8'h06, 8'h06), 1'b0, 1'b0);
        do_op(4'b0101, 4'b0110, pick(8'h1E, 8'h1E), 1'b1, 1'b0);
        do_op(4'b1001, 4'b0111, pick(8'h3F, 8'hCF), 1'b1, 1'b0);
        do_op(4'b1100, 4'b1101, pick(8'h9C, 8'h0C), 1'b1, 1'b0);
        start = 1'b0;

        repeat (4) @(posedge clk);
        #1;
        chk("final_idle", busy, 0);
        chk("done_count", n_done, n_ops);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
